switch_arb: RTL and testbench
=============================

SWITCH_ARB -- requirements
Module: switch_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the switch input port.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-003 Parameter DATA_W, default 16, SHALL set the data width.
REQ-004 Parameter BURST_MAX, default 4, SHALL set the maximum consecutive beats one requester may be granted before rotation.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, SHALL be the reset, asynchronous and active-low.
REQ-007 req, input, NUM_REQ, SHALL carry per-requester request; requester holds req_addr/req_data stable while req is high and gnt is low.
REQ-008 req_addr, input, NUM_REQ x ADDR_W, SHALL carry per-requester destination address.
REQ-009 req_data, input, NUM_REQ x DATA_W, SHALL carry per-requester payload.
REQ-010 req_mask, input, NUM_REQ, SHALL exclude requester i from arbitration when bit i is 1.
REQ-011 gnt, output, NUM_REQ, SHALL be one-hot or zero, indicating the beat accepted this cycle.
REQ-012 sw_addr, output, ADDR_W, SHALL drive the switch addr input.
REQ-013 sw_data, output, DATA_W, SHALL drive the switch data input.
REQ-014 sw_valid, output, 1, SHALL drive the switch valid input.
REQ-015 busy, output, 1, SHALL be 1 while state is BURST.

Function
REQ-016 Eligible requester i SHALL mean req[i]=1 and req_mask[i]=0.
REQ-017 gnt SHALL be combinational from current state and eligible set; a requester's beat is transferred in every cycle its gnt bit is 1.
REQ-018 Captured beat SHALL appear on sw_addr/sw_data with sw_valid=1 exactly one cycle after gnt (latency 1); sw_valid=0 in cycles following no grant, sw_addr/sw_data hold last value.
REQ-019 FSM states SHALL be IDLE (no owner) and BURST (owner o, beat count c).
REQ-020 IDLE: if any eligible, grant round-robin winner, go BURST with c=1; else stay IDLE, gnt=0.
REQ-021 BURST: if o eligible and c<BURST_MAX, grant o, c=c+1.
REQ-022 BURST: if o not eligible or c=BURST_MAX, rearbitrate in the same cycle (no bubble); winner gets c=1; no eligible -> IDLE.
REQ-023 Round-robin search SHALL start at index (last owner+1) mod NUM_REQ and wrap; last owner is lowest priority, may be regranted if sole eligible (no bubble).
REQ-024 Pointer after reset SHALL be such that search starts at index 0.
REQ-025 Beat counter width SHALL be $clog2(BURST_MAX+1); it never exceeds BURST_MAX.
REQ-026 Mask change SHALL take effect in the same cycle's arbitration, including ending an owner's burst.

Reset
REQ-027 While rst_n=0: gnt=0, sw_valid=0, sw_addr=0, sw_data=0, busy=0, state IDLE, c=0, search pointer at 0.
REQ-028 Reset asserted mid-burst SHALL drop sw_valid and gnt immediately (asynchronous); no partial burst resumes after release.
REQ-029 First rising edge after rst_n release SHALL be able to grant.

Structure
REQ-030 Package switch_arb_pkg SHALL hold default ADDR_W, DATA_W, NUM_REQ, BURST_MAX and the state enum (IDLE, BURST).
REQ-031 Round-robin selection SHALL be a sub-module rr_pick (inputs eligible vector and start index; outputs one-hot winner and valid).
REQ-032 switch_arb SHALL contain only the FSM, counter, pointer and output registers.

Verification
REQ-033 Only req[0], 3 beats addr 0x12/0x13/0x14, data 0xA001..3 -> gnt[0] three cycles, sw_valid three cycles delayed by 1 with identical values.
REQ-034 All four req held high, BURST_MAX=4 -> gnt sequence 0x4,1x4,2x4,3x4,0x4..., sw_valid continuously 1, no bubble.
REQ-035 After reset, req[1] and req[3] high -> requester 1 granted 4 beats, then 3 for 4 beats, then 1.
REQ-036 Requester 2 owns burst at c=2, req_mask[2] set, req[3] high -> gnt switches to bit 3 in that cycle, c=1.
REQ-037 Only req[0] held high for 10 cycles -> gnt[0]=1 all 10 cycles, rotation at beat 4/8 causes no gap.
REQ-038 rst_n low mid-burst -> sw_valid, gnt, busy 0 without clock edge; after release with all req high, requester 0 granted first.

Source files
------------

// File: rtl/switch_arb_pkg.sv
// switch_arb_pkg: default sizes and FSM state type shared by the switch arbiter files
package switch_arb_pkg;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BURST_MAX = 4;
    typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/switch_arb_rr_pick.sv
// rr_pick: round-robin winner search over an eligible vector
// ports: elig (eligible requesters), start (first index searched, wraps),
//        win (one-hot winner or zero), valid (any eligible)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  win,
    output logic          valid
);
    logic [IW:0] j;
    logic        found;
    assign valid = |elig;
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, start} + (IW+1)'(k);
            j = j >= (IW+1)'(N) ? j - (IW+1)'(N) : j;
            if (!found && elig[j[IW-1:0]]) begin
                win[j[IW-1:0]] = 1'b1;
                found          = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_arb.sv
// switch_arb: burst-limited round-robin arbiter feeding one switch input port
// ports: clk, rst_n (async active-low); req/req_mask per requester with
//        req_addr/req_data payloads; gnt (one-hot beat accepted this cycle);
//        sw_addr/sw_data/sw_valid (registered beat, one cycle after gnt); busy (in BURST)
module switch_arb
    import switch_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_mask,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [ADDR_W-1:0]              sw_addr,
    output logic [DATA_W-1:0]              sw_data,
    output logic                           sw_valid,
    output logic                           busy
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(BURST_MAX);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    state_t             state, state_nx;
    logic [IW-1:0]      owner, owner_nx, ptr, ptr_nx, win_idx, sel;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [NUM_REQ-1:0] elig, win, own_oh, gnt_i;
    logic               win_vld, keep;

    assign elig = req & ~req_mask;

    // ptr always holds (last owner + 1) mod NUM_REQ, so the same search serves
    // both IDLE arbitration and in-burst rotation
    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .elig  (elig),
        .start (ptr),
        .win   (win),
        .valid (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            win_idx = win[i] ? IW'(i) : win_idx;
        own_oh        = '0;
        own_oh[owner] = 1'b1;
        keep     = state == BURST && elig[owner] && cnt < CMAX;
        sel      = keep ? owner : win_idx;
        gnt_i    = keep ? own_oh : (win_vld ? win : '0);
        state_nx = keep || win_vld ? BURST : IDLE;
        owner_nx = keep || !win_vld ? owner : win_idx;
        cnt_nx   = keep ? cnt + CW'(1) : (win_vld ? CW'(1) : '0);
        ptr_nx   = !keep && win_vld ? (win_idx == LAST ? '0 : win_idx + IW'(1)) : ptr;
    end

    // gnt is gated by rst_n so it drops asynchronously even with requests pending
    assign gnt  = rst_n ? gnt_i : '0;
    assign busy = state == BURST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            cnt      <= '0;
            ptr      <= '0;
            sw_valid <= 1'b0;
            sw_addr  <= '0;
            sw_data  <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            cnt      <= cnt_nx;
            ptr      <= ptr_nx;
            sw_valid <= |gnt_i;
            if (|gnt_i) begin
                sw_addr <= req_addr[sel];
                sw_data <= req_data[sel];
            end
        end
    end
endmodule

// File: tb/tb_switch_arb.sv
// tb_switch_arb: directed self-checking bench for switch_arb
module tb_switch_arb;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req, req_mask, gnt;
    logic [3:0][7:0]  req_addr;
    logic [3:0][15:0] req_data;
    logic [7:0]       sw_addr;
    logic [15:0]      sw_data;
    logic             sw_valid, busy;
    int               checks = 0;
    int               errors = 0;
    int               e;

    switch_arb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_mask (req_mask),
        .gnt      (gnt),
        .sw_addr  (sw_addr),
        .sw_data  (sw_data),
        .sw_valid (sw_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'hF;
        req_mask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 8'h40 + 8'(i);
            req_data[i] = 16'hD000 + 16'(i);
        end
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", sw_valid, 0);
        chk("rst_addr", sw_addr, 0);
        chk("rst_data", sw_data, 0);
        chk("rst_busy", busy, 0);
        req   = 4'h0;
        rst_n = 1'b1;

        // single requester, three beats with changing payload
        req = 4'h1; req_addr[0] = 8'h12; req_data[0] = 16'hA001;
        #1; chk("b1_gnt", gnt, 1);
        tick();
        chk("b1_valid", sw_valid, 1); chk("b1_addr", sw_addr, 8'h12);
        chk("b1_data", sw_data, 16'hA001); chk("b1_busy", busy, 1);
        req_addr[0] = 8'h13; req_data[0] = 16'hA002;
        #1; chk("b2_gnt", gnt, 1);
        tick();
        chk("b2_addr", sw_addr, 8'h13); chk("b2_data", sw_data, 16'hA002);
        req_addr[0] = 8'h14; req_data[0] = 16'hA003;
        #1; chk("b3_gnt", gnt, 1);
        tick();
        chk("b3_valid", sw_valid, 1); chk("b3_addr", sw_addr, 8'h14); chk("b3_data", sw_data, 16'hA003);
        req = 4'h0;
        #1; chk("idle_gnt", gnt, 0);
        tick();
        chk("idle_valid", sw_valid, 0); chk("hold_addr", sw_addr, 8'h14);
        chk("hold_data", sw_data, 16'hA003); chk("idle_busy", busy, 0);

        // everything masked: nothing eligible
        req = 4'hF; req_mask = 4'hF;
        #1; chk("mask_gnt", gnt, 0);
        tick();
        chk("mask_busy", busy, 0); chk("mask_valid", sw_valid, 0);
        req = 4'h0; req_mask = 4'h0;
        req_addr[0] = 8'h40; req_data[0] = 16'hD000;

        // all requesting: 4 beats each in rotation, no bubble
        pulse_reset();
        req = 4'hF;
        for (int n = 0; n < 20; n++) begin
            e = (n / 4) % 4;
            #1; chk("rot_gnt", gnt, 32'(1) << e);
            tick();
            chk("rot_valid", sw_valid, 1);
            chk("rot_addr", sw_addr, 32'h40 + 32'(e));
        end

        // async reset mid-burst, then requester 0 wins first
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0); chk("arst_valid", sw_valid, 0); chk("arst_busy", busy, 0);
        rst_n = 1'b1;
        #1; chk("rel_gnt", gnt, 1);
        tick();
        chk("rel_valid", sw_valid, 1); chk("rel_addr", sw_addr, 8'h40);

        // requesters 1 and 3 alternate in bursts of 4
        pulse_reset();
        req = 4'hA;
        for (int n = 0; n < 12; n++) begin
            #1; chk("alt_gnt", gnt, n < 4 ? 2 : (n < 8 ? 8 : 2));
            tick();
        end

        // masking the owner mid-burst hands over in the same cycle with a fresh count
        pulse_reset();
        req = 4'h4;
        #1; chk("own_gnt1", gnt, 4);
        tick();
        #1; chk("own_gnt2", gnt, 4);
        tick();
        req = 4'hC; req_mask = 4'h4;
        #1; chk("sw_gnt", gnt, 8);
        tick();
        chk("sw_addr3", sw_addr, 8'h43); chk("sw_busy", busy, 1);
        req_mask = 4'h0;
        for (int n = 0; n < 3; n++) begin
            #1; chk("new_gnt", gnt, 8);
            tick();
        end
        #1; chk("back_gnt", gnt, 4);
        tick();
        req = 4'h0;

        // sole requester continues across burst boundaries without a gap
        pulse_reset();
        req = 4'h1;
        for (int n = 0; n < 10; n++) begin
            #1; chk("sole_gnt", gnt, 1);
            tick();
            chk("sole_valid", sw_valid, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
